// File: rtl/spi_pkg.sv
// Shared constants and types for the 10-bit command/data SPI frame protocol.
package spi_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Host frame: command in the top two bits, address/data below.
  typedef struct packed {
    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
  } frame_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    TURN,
    RECV,
    HOLD
  } mst_state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response bundle of the SPI master.
interface spi_master_if;
  import spi_pkg::*;

  logic              start;
  frame_t            cmd_data;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output start, cmd_data,
    input  ready, done, rd_data, rd_valid
  );

  modport slave (
    input  start, cmd_data,
    output ready, done, rd_data, rd_valid
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, idle-low SCLK register and edge strobes.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = clog2_min1(HALF_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic             tc_c;

  // Strobes flag the clk edge on which SCLK will change.
  assign tc_c   = en && (cnt_q == CNT_W'(HALF_DIV - 1));
  assign rise_c = tc_c && !sclk;
  assign fall_c = tc_c && sclk;

  // Counter and SCLK register; both collapse to idle whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (tc_c) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: serialises a 10-bit frame MSB-first and captures the
// 8-bit reply on read-data frames.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2,
  parameter int unsigned RD_TURN  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  host,
  output logic         SS_n,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO
);

  localparam int unsigned TURN_W = clog2_min1(RD_TURN + 1);
  localparam int unsigned HOLD_W = clog2_min1(2 * HALF_DIV);

  mst_state_e          state_q;
  logic [FRAME_W-1:0]  tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [3:0]          bit_cnt;
  logic [TURN_W-1:0]   turn_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                is_rd_q;
  logic                sclk_en_c;
  logic                rise_c;
  logic                fall_c;

  // SCLK only runs while the slave is selected.
  assign sclk_en_c = !SS_n;

  spi_sclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sclk_en_c),
    .sclk   (SCLK),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Frame sequencer with registered host and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      host.ready    <= 1'b1;
      host.done     <= 1'b0;
      host.rd_valid <= 1'b0;
      host.rd_data  <= '0;
      SS_n          <= 1'b1;
      MOSI          <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      bit_cnt       <= '0;
      turn_cnt      <= '0;
      hold_cnt      <= '0;
      is_rd_q       <= 1'b0;
    end else begin
      host.done     <= 1'b0;
      host.rd_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (host.start) begin
            tx_sr      <= host.cmd_data;
            is_rd_q    <= (host.cmd_data.cmd == CMD_RD_DATA);
            host.ready <= 1'b0;
            SS_n       <= 1'b0;
            bit_cnt    <= '0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (fall_c) begin
            MOSI    <= tx_sr[FRAME_W-1];
            tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
            bit_cnt <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (fall_c) begin
            if (bit_cnt == 4'd9) begin
              MOSI     <= 1'b0;
              bit_cnt  <= '0;
              turn_cnt <= '0;
              if (!is_rd_q) begin
                SS_n     <= 1'b1;
                hold_cnt <= '0;
                state_q  <= HOLD;
              end else if (RD_TURN > 0) begin
                state_q <= TURN;
              end else begin
                state_q <= RECV;
              end
            end else begin
              MOSI    <= tx_sr[FRAME_W-1];
              tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        TURN: begin
          if (fall_c) begin
            if (turn_cnt == TURN_W'(RD_TURN - 1)) begin
              bit_cnt <= '0;
              state_q <= RECV;
            end else begin
              turn_cnt <= turn_cnt + TURN_W'(1);
            end
          end
        end
        RECV: begin
          if (rise_c) begin
            rx_sr <= {rx_sr[DATA_W-2:0], MISO};
          end
          if (fall_c) begin
            if (bit_cnt == 4'd7) begin
              SS_n     <= 1'b1;
              hold_cnt <= '0;
              state_q  <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(2 * HALF_DIV - 1)) begin
            hold_cnt   <= '0;
            host.ready <= 1'b1;
            state_q    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            // Raise done for the final HOLD cycle.
            if (hold_cnt == HOLD_W'(2 * HALF_DIV - 2)) begin
              host.done     <= 1'b1;
              host.rd_valid <= is_rd_q;
              if (is_rd_q) begin
                host.rd_data <= rx_sr;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of frames plus multi-cycle corner cases.
module tb_spi_master;
  import spi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic ss_n0, sclk0, mosi0;
  logic miso0 = 1'b0;
  logic ss_n1, sclk1, mosi1;
  logic miso1 = 1'b0;

  spi_master_if h0();
  spi_master_if h1();

  spi_master #(.HALF_DIV(2), .RD_TURN(2)) dut (
    .clk(clk), .rst_n(rst_n), .host(h0),
    .SS_n(ss_n0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0)
  );

  spi_master #(.HALF_DIV(1), .RD_TURN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(h1),
    .SS_n(ss_n1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wire monitor and slave reply model for the HALF_DIV=2, RD_TURN=2 instance.
  logic        p_ss0 = 1'b1, p_sclk0 = 1'b0;
  int          cur_len0 = 0, cur_rises0 = 0, cur_falls0 = 0, hi_len0 = 0;
  logic [31:0] cur_mosi0 = '0, last_mosi0 = '0;
  int          last_len0 = 0, last_rises0 = 0, last_gap0 = 0, frames0 = 0;
  int          done_cnt0 = 0, rdv_cnt0 = 0, rdv_nodone0 = 0;
  logic [7:0]  rdv_data0 = '0, miso_byte0 = '0;

  always @(negedge clk) begin
    if (p_ss0 && !ss_n0) begin
      last_gap0 = hi_len0; cur_len0 = 0; cur_rises0 = 0; cur_falls0 = 0;
      cur_mosi0 = '0; miso0 = 1'b0;
    end
    if (!p_ss0 && ss_n0) begin
      last_len0 = cur_len0; last_rises0 = cur_rises0; last_mosi0 = cur_mosi0;
      frames0++; hi_len0 = 0;
    end
    if (!ss_n0) cur_len0++; else hi_len0++;
    if (sclk0 && !p_sclk0) begin
      cur_rises0++;
      cur_mosi0 = {cur_mosi0[30:0], mosi0};
    end
    if (!sclk0 && p_sclk0) begin
      cur_falls0++;
      if (cur_falls0 >= 13 && cur_falls0 <= 20) miso0 = miso_byte0[3'(20 - cur_falls0)];
      else miso0 = 1'b0;
    end
    if (h0.done) done_cnt0++;
    if (h0.rd_valid) begin
      rdv_cnt0++;
      rdv_data0 = h0.rd_data;
      if (!h0.done) rdv_nodone0++;
    end
    p_ss0 = ss_n0; p_sclk0 = sclk0;
  end

  // Same monitor for the HALF_DIV=1, RD_TURN=0 instance.
  logic        p_ss1 = 1'b1, p_sclk1 = 1'b0;
  int          cur_len1 = 0, cur_rises1 = 0, cur_falls1 = 0;
  logic [31:0] cur_mosi1 = '0, last_mosi1 = '0;
  int          last_len1 = 0, last_rises1 = 0, done_cnt1 = 0, rdv_cnt1 = 0;
  logic [7:0]  rdv_data1 = '0, miso_byte1 = '0;

  always @(negedge clk) begin
    if (p_ss1 && !ss_n1) begin
      cur_len1 = 0; cur_rises1 = 0; cur_falls1 = 0; cur_mosi1 = '0; miso1 = 1'b0;
    end
    if (!p_ss1 && ss_n1) begin
      last_len1 = cur_len1; last_rises1 = cur_rises1; last_mosi1 = cur_mosi1;
    end
    if (!ss_n1) cur_len1++;
    if (sclk1 && !p_sclk1) begin
      cur_rises1++;
      cur_mosi1 = {cur_mosi1[30:0], mosi1};
    end
    if (!sclk1 && p_sclk1) begin
      cur_falls1++;
      if (cur_falls1 >= 11 && cur_falls1 <= 18) miso1 = miso_byte1[3'(18 - cur_falls1)];
      else miso1 = 1'b0;
    end
    if (h1.done) done_cnt1++;
    if (h1.rd_valid) begin
      rdv_cnt1++;
      rdv_data1 = h1.rd_data;
    end
    p_ss1 = ss_n1; p_sclk1 = sclk1;
  end

  typedef struct {
    logic [9:0]  cmd;
    logic [7:0]  miso;
    int          len;
    int          rises;
    logic [31:0] mosi;
    int          rdv;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs[6];

  // Issue one frame on instance 0 and compare the wire and host results.
  task automatic do_vec(input vec_t v, input string tag);
    int d0, r0, i;
    d0 = done_cnt0; r0 = rdv_cnt0;
    i = 0;
    while (!h0.ready && i < 200) begin tick(); i++; end
    miso_byte0  = v.miso;
    h0.cmd_data = v.cmd;
    h0.start    = 1'b1;
    tick();
    h0.start = 1'b0;
    i = 0;
    while (done_cnt0 == d0 && i < 400) begin tick(); i++; end
    tick(); tick();
    check({tag, ".ss_len"}, last_len0, v.len);
    check({tag, ".sclk_periods"}, last_rises0, v.rises);
    check({tag, ".mosi"}, last_mosi0, v.mosi);
    check({tag, ".done_pulses"}, done_cnt0 - d0, 1);
    check({tag, ".rd_valid_pulses"}, rdv_cnt0 - r0, v.rdv);
    check({tag, ".rd_data"}, h0.rd_data, v.rd);
    if (v.rdv != 0) check({tag, ".rd_data_at_valid"}, rdv_data0, v.rd);
    check({tag, ".ready"}, h0.ready, 1);
  endtask

  initial begin
    int f0, d0, i;
    vec_t fresh;

    h0.start = 1'b0; h0.cmd_data = '0;
    h1.start = 1'b0; h1.cmd_data = '0;

    vecs[0] = '{10'h0A5, 8'hFF, 44, 11, 32'h000A5, 0, 8'h00};
    vecs[1] = '{10'h300, 8'h3C, 84, 21, 32'hC0000, 1, 8'h3C};
    vecs[2] = '{10'h25A, 8'h00, 44, 11, 32'h0025A, 0, 8'h3C};
    vecs[3] = '{10'h3FF, 8'hA5, 84, 21, 32'hFFC00, 1, 8'hA5};
    vecs[4] = '{10'h13C, 8'h55, 44, 11, 32'h0013C, 0, 8'hA5};
    vecs[5] = '{10'h381, 8'h81, 84, 21, 32'hE0400, 1, 8'h81};

    // Reset values, during and just after reset.
    repeat (3) tick();
    check("rst.ready", h0.ready, 1);
    check("rst.done", h0.done, 0);
    check("rst.rd_valid", h0.rd_valid, 0);
    check("rst.rd_data", h0.rd_data, 0);
    check("rst.ss_n", ss_n0, 1);
    check("rst.sclk", sclk0, 0);
    check("rst.mosi", mosi0, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst.ready", h0.ready, 1);
    check("post_rst.ss_n", ss_n0, 1);

    for (int k = 0; k < 6; k++) do_vec(vecs[k], $sformatf("vec%0d", k));

    // Busy rejection: start mid-frame and in the done cycle.
    f0 = frames0; d0 = done_cnt0;
    h0.cmd_data = 10'h2C3; h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    repeat (20) tick();
    h0.cmd_data = 10'h1FF; h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    i = 0;
    while (!h0.done && i < 200) begin tick(); i++; end
    check("busy.done_seen", h0.done, 1);
    h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    repeat (60) tick();
    check("busy.frames", frames0 - f0, 1);
    check("busy.done_pulses", done_cnt0 - d0, 1);
    check("busy.mosi", last_mosi0, 32'h2C3);
    check("busy.ss_len", last_len0, 44);
    check("busy.rd_data_kept", h0.rd_data, 8'h81);

    // Back-to-back with start held high.
    f0 = frames0; d0 = done_cnt0;
    h0.cmd_data = 10'h0A5; h0.start = 1'b1;
    tick();
    h0.cmd_data = 10'h16B;
    i = 0;
    while (frames0 < f0 + 1 && i < 200) begin tick(); i++; end
    check("b2b.len1", last_len0, 44);
    check("b2b.mosi1", last_mosi0, 32'h0A5);
    i = 0;
    while (ss_n0 && i < 40) begin tick(); i++; end
    h0.start = 1'b0;
    check("b2b.gap", last_gap0, 5);
    i = 0;
    while (frames0 < f0 + 2 && i < 200) begin tick(); i++; end
    check("b2b.len2", last_len0, 44);
    check("b2b.mosi2", last_mosi0, 32'h16B);
    repeat (10) tick();
    check("b2b.done_pulses", done_cnt0 - d0, 2);
    check("b2b.frames", frames0 - f0, 2);

    // Reset in the middle of SEND.
    d0 = done_cnt0;
    h0.cmd_data = 10'h0A5; h0.start = 1'b1;
    tick();
    h0.start = 1'b0;
    i = 0;
    while (cur_rises0 < 6 && i < 100) begin tick(); i++; end
    check("midrst.reached_send", cur_rises0, 6);
    rst_n = 1'b0;
    #1;
    check("midrst.ss_n", ss_n0, 1);
    check("midrst.sclk", sclk0, 0);
    check("midrst.mosi", mosi0, 0);
    check("midrst.ready", h0.ready, 1);
    check("midrst.rd_data", h0.rd_data, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("midrst.no_done", done_cnt0 - d0, 0);
    fresh = '{10'h2C3, 8'h00, 44, 11, 32'h002C3, 0, 8'h00};
    do_vec(fresh, "midrst.fresh");

    // Fastest build: HALF_DIV=1, RD_TURN=0 read-data frame.
    miso_byte1 = 8'hA5;
    h1.cmd_data = 10'h300; h1.start = 1'b1;
    tick();
    h1.start = 1'b0;
    i = 0;
    while (done_cnt1 == 0 && i < 200) begin tick(); i++; end
    tick(); tick();
    check("fast.ss_len", last_len1, 38);
    check("fast.sclk_periods", last_rises1, 19);
    check("fast.mosi", last_mosi1, 32'h30000);
    check("fast.rd_data", h1.rd_data, 8'hA5);
    check("fast.rd_valid_pulses", rdv_cnt1, 1);
    check("fast.rd_data_at_valid", rdv_data1, 8'hA5);
    check("fast.done_pulses", done_cnt1, 1);

    check("rd_valid_without_done", rdv_nodone0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
